puf_race_launcher: RTL

Launch-side controller for the PUF arbiter cell. Per challenge it drives rising edges on two race lines with a programmable cycle skew and a chosen leading line, waits for the arbiter to settle, and samples the arbiter output. It then returns both lines low and repeats for a programmed number of trials. The block sits between the PUF control registers and the arbiter cell, and reports a majority-vote response bit plus the raw count of ones.

---
 rtl/puf_launch_pkg.sv | 30 +++
 rtl/puf_launch_cnt.sv | 27 ++
 rtl/puf_race_launcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/puf_launch_pkg.sv
// rtl/puf_launch_pkg.sv - FSM states, default sizing and lead encoding for the PUF race launcher
package puf_launch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAG,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RELEASE,
    ST_DONE
  } state_t;

  localparam int DEF_DLY_W    = 4;
  localparam int DEF_REP_W    = 5;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_LOW_HOLD = 2;

  localparam logic LEAD_A = 1'b0;
  localparam logic LEAD_B = 1'b1;

  // One shared interval counter must hold skew-1, SETTLE-1 and LOW_HOLD-1.
  function automatic int cnt_width(input int dly_w, input int settle, input int low_hold);
    int w;
    w = (dly_w > 1) ? dly_w : 1;
    if ($clog2(settle) > w) w = $clog2(settle);
    if ($clog2(low_hold) > w) w = $clog2(low_hold);
    return w;
  endfunction

endpackage

// File: rtl/puf_launch_cnt.sv
// rtl/puf_launch_cnt.sv - loadable down-counter with zero flag, shared by the LAG/SETTLE/RELEASE intervals
module puf_launch_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/puf_race_launcher.sv
// rtl/puf_race_launcher.sv - PUF race-line launch FSM with majority vote; PUF_LAUNCH_ABORT_EN adds an abort input
module puf_race_launcher
  import puf_launch_pkg::*;
#(
  parameter int DLY_W    = DEF_DLY_W,
  parameter int REP_W    = DEF_REP_W,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int LOW_HOLD = DEF_LOW_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DLY_W-1:0] skew,
  input  logic             lead_b,
  input  logic [REP_W-1:0] reps,
  input  logic             arb_in,
`ifdef PUF_LAUNCH_ABORT_EN
  input  logic             abort,
`endif
  output logic             launch_a,
  output logic             launch_b,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic [REP_W-1:0] ones_cnt
);

  localparam int CNT_W = cnt_width(DLY_W, SETTLE, LOW_HOLD);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LOW_LD    = CNT_W'(LOW_HOLD - 1);

  state_t             state_q, state_d;
  logic [DLY_W-1:0]   skew_q;
  logic               lead_q;
  logic [REP_W-1:0]   reps_q, trial_q;
  logic               aborted_q, abort_req, abort_hit, stop, relaunch, accept;
  logic               cnt_load, cnt_dec, cnt_zero, sample_en, a_d, b_d;
  logic [CNT_W-1:0]   cnt_val;

`ifdef PUF_LAUNCH_ABORT_EN
  assign abort_req = abort && (state_q inside {ST_LAG, ST_SETTLE, ST_SAMPLE, ST_RELEASE});
`else
  assign abort_req = 1'b0;
`endif
  // An abort already in RELEASE only marks the run; the lines are low there anyway.
  assign abort_hit = abort_req && (state_q inside {ST_LAG, ST_SETTLE, ST_SAMPLE});
  assign stop      = aborted_q || abort_req;
  assign relaunch  = (trial_q < reps_q) && !stop;
  assign accept    = (state_q == ST_IDLE) && start;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  puf_launch_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = (skew == '0) ? ST_SETTLE : ST_LAG;
      ST_LAG:     if (cnt_zero) state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_zero) state_d = ST_SAMPLE;
      ST_SAMPLE:  state_d = ST_RELEASE;
      ST_RELEASE: if (cnt_zero) state_d = !relaunch ? ST_DONE : (skew_q == '0) ? ST_SETTLE : ST_LAG;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_RELEASE;
  end

  // Zero skew skips LAG entirely: both lines rise together and SETTLE is loaded directly.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    sample_en = 1'b0;
    a_d       = launch_a;
    b_d       = launch_b;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_load   = 1'b1;
        cnt_val    = (skew == '0) ? SETTLE_LD : CNT_W'(skew) - CNT_W'(1);
        {a_d, b_d} = (skew == '0) ? 2'b11 : (lead_b == LEAD_B) ? 2'b01 : 2'b10;
      end
      ST_LAG: if (cnt_zero) begin
        cnt_load   = 1'b1;
        cnt_val    = SETTLE_LD;
        {a_d, b_d} = 2'b11;
      end else begin
        cnt_dec = 1'b1;
      end
      ST_SETTLE: cnt_dec = !cnt_zero;
      ST_SAMPLE: begin
        sample_en  = 1'b1;
        cnt_load   = 1'b1;
        cnt_val    = LOW_LD;
        {a_d, b_d} = 2'b00;
      end
      ST_RELEASE: if (!cnt_zero) begin
        cnt_dec = 1'b1;
      end else if (relaunch) begin
        cnt_load   = 1'b1;
        cnt_val    = (skew_q == '0) ? SETTLE_LD : CNT_W'(skew_q) - CNT_W'(1);
        {a_d, b_d} = (skew_q == '0) ? 2'b11 : (lead_q == LEAD_B) ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
    if (abort_hit) begin
      cnt_load   = 1'b1;
      cnt_val    = LOW_LD;
      cnt_dec    = 1'b0;
      sample_en  = 1'b0;
      {a_d, b_d} = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      launch_a  <= 1'b0;
      launch_b  <= 1'b0;
      result    <= 1'b0;
      ones_cnt  <= '0;
      trial_q   <= '0;
      skew_q    <= '0;
      lead_q    <= LEAD_A;
      reps_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      launch_a <= a_d;
      launch_b <= b_d;
      if (accept) begin
        skew_q    <= skew;
        lead_q    <= lead_b;
        reps_q    <= (reps == '0) ? REP_W'(1) : reps;
        trial_q   <= '0;
        ones_cnt  <= '0;
        aborted_q <= 1'b0;
        result    <= 1'b0;
      end
      if (sample_en) begin
        trial_q <= trial_q + REP_W'(1);
        if (arb_in) ones_cnt <= ones_cnt + REP_W'(1);
      end
      if (abort_req) aborted_q <= 1'b1;
      if ((state_q == ST_RELEASE) && (state_d == ST_DONE))
        result <= !stop && ({ones_cnt, 1'b0} > {1'b0, reps_q});
    end
  end

endmodule
